// File: rtl/video_pattern_gen_pkg.sv
// Shared definitions for the video pattern generator: pattern modes and colour-bar table.
package video_pattern_gen_pkg;

  typedef enum logic [2:0] {
    MODE_FADE    = 3'd0,
    MODE_BARS    = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_RAMP    = 3'd3,
    MODE_MOVBAR  = 3'd4
  } mode_e;

  localparam int NUM_BARS = 8;
  localparam int MOVBAR_W = 16;

  // {r,g,b} on/off per bar, index 0 is the leftmost bar:
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [NUM_BARS-1:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic logic [2:0] bar_colour(input logic [3:0] idx);
    bar_colour = (idx < 4'(NUM_BARS)) ? BAR_RGB[idx[2:0]] : 3'b000;
  endfunction

endpackage

// File: rtl/vtg_timing.sv
// Video timing core: H/V counters, per-frame configuration shadow, legality check,
// and unregistered active/sync decode for the pattern stage.
module vtg_timing #(
  parameter int CNT_W = 12
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst_n,
  input  logic [CNT_W-1:0] I_h_total,
  input  logic [CNT_W-1:0] I_h_sync,
  input  logic [CNT_W-1:0] I_h_bporch,
  input  logic [CNT_W-1:0] I_h_res,
  input  logic [CNT_W-1:0] I_v_total,
  input  logic [CNT_W-1:0] I_v_sync,
  input  logic [CNT_W-1:0] I_v_bporch,
  input  logic [CNT_W-1:0] I_v_res,
  input  logic             I_hs_pol,
  input  logic             I_vs_pol,
  input  logic [2:0]       I_mode,
  input  logic [3:0]       I_chk_log2,
  output logic             frame_start,
  output logic             frame_end,
  output logic             line_end,
  output logic             active,
  output logic             hs_lvl,
  output logic             vs_lvl,
  output logic             cfg_err,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [CNT_W-1:0] h_res,
  output logic [2:0]       mode,
  output logic [3:0]       chk_log2
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_total_q, h_sync_q, h_bporch_q, h_res_q;
  logic [CNT_W-1:0] v_total_q, v_sync_q, v_bporch_q, v_res_q;
  logic             hs_pol_q, vs_pol_q, err_q;
  logic [2:0]       mode_q;
  logic [3:0]       chk_q;

  logic [CNT_W-1:0] h_total_e, h_sync_e, h_bporch_e, h_res_e;
  logic [CNT_W-1:0] v_total_e, v_sync_e, v_bporch_e, v_res_e;
  logic             hs_pol_e, vs_pol_e, illegal_in;
  logic [CNT_W:0]   h_nxt, v_nxt, h_start, v_start, h_off, v_off;
  logic             h_act, v_act;

  // A span overflows the total; checked in two steps so no sum exceeds CNT_W+1 bits.
  function automatic logic span_illegal(input logic [CNT_W-1:0] sync, input logic [CNT_W-1:0] bporch,
                                        input logic [CNT_W-1:0] res, input logic [CNT_W-1:0] total);
    logic [CNT_W:0] lead;
    lead = {1'b0, sync} + {1'b0, bporch};
    span_illegal = (lead > {1'b0, total}) || ({1'b0, res} > ({1'b0, total} - lead));
  endfunction

  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

  // On the latch cycle the raw inputs are used, so pixel (0,0) already sees the new frame's setup.
  assign h_total_e  = frame_start ? I_h_total  : h_total_q;
  assign h_sync_e   = frame_start ? I_h_sync   : h_sync_q;
  assign h_bporch_e = frame_start ? I_h_bporch : h_bporch_q;
  assign h_res_e    = frame_start ? I_h_res    : h_res_q;
  assign v_total_e  = frame_start ? I_v_total  : v_total_q;
  assign v_sync_e   = frame_start ? I_v_sync   : v_sync_q;
  assign v_bporch_e = frame_start ? I_v_bporch : v_bporch_q;
  assign v_res_e    = frame_start ? I_v_res    : v_res_q;
  assign hs_pol_e   = frame_start ? I_hs_pol   : hs_pol_q;
  assign vs_pol_e   = frame_start ? I_vs_pol   : vs_pol_q;
  assign mode       = frame_start ? I_mode     : mode_q;
  assign chk_log2   = frame_start ? I_chk_log2 : chk_q;
  assign h_res      = h_res_e;

  assign illegal_in = span_illegal(I_h_sync, I_h_bporch, I_h_res, I_h_total) ||
                      span_illegal(I_v_sync, I_v_bporch, I_v_res, I_v_total) ||
                      (I_h_total < CNT_W'(2)) || (I_v_total < CNT_W'(2));
  assign cfg_err    = frame_start ? illegal_in : err_q;

  assign h_nxt     = {1'b0, h_cnt} + (CNT_W+1)'(1);
  assign v_nxt     = {1'b0, v_cnt} + (CNT_W+1)'(1);
  assign line_end  = h_nxt >= {1'b0, h_total_e};
  assign frame_end = line_end && (v_nxt >= {1'b0, v_total_e});

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= frame_end ? '0 : v_nxt[CNT_W-1:0];
    end else begin
      h_cnt <= h_nxt[CNT_W-1:0];
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_total_q  <= '0;
      h_sync_q   <= '0;
      h_bporch_q <= '0;
      h_res_q    <= '0;
      v_total_q  <= '0;
      v_sync_q   <= '0;
      v_bporch_q <= '0;
      v_res_q    <= '0;
      hs_pol_q   <= 1'b0;
      vs_pol_q   <= 1'b0;
      mode_q     <= '0;
      chk_q      <= '0;
      err_q      <= 1'b0;
    end else if (frame_start) begin
      h_total_q  <= I_h_total;
      h_sync_q   <= I_h_sync;
      h_bporch_q <= I_h_bporch;
      h_res_q    <= I_h_res;
      v_total_q  <= I_v_total;
      v_sync_q   <= I_v_sync;
      v_bporch_q <= I_v_bporch;
      v_res_q    <= I_v_res;
      hs_pol_q   <= I_hs_pol;
      vs_pol_q   <= I_vs_pol;
      mode_q     <= I_mode;
      chk_q      <= I_chk_log2;
      err_q      <= illegal_in;
    end
  end

  assign h_start = {1'b0, h_sync_e} + {1'b0, h_bporch_e};
  assign v_start = {1'b0, v_sync_e} + {1'b0, v_bporch_e};
  assign h_off   = {1'b0, h_cnt} - h_start;
  assign v_off   = {1'b0, v_cnt} - v_start;
  assign h_act   = ({1'b0, h_cnt} >= h_start) && (h_off < {1'b0, h_res_e});
  assign v_act   = ({1'b0, v_cnt} >= v_start) && (v_off < {1'b0, v_res_e});
  assign active  = h_act && v_act;
  assign x       = h_off[CNT_W-1:0];
  assign y       = v_off[CNT_W-1:0];

  assign hs_lvl  = ~((h_cnt < h_sync_e) ^ hs_pol_e);
  assign vs_lvl  = ~((v_cnt < v_sync_e) ^ vs_pol_e);

endmodule

// File: rtl/video_pattern_gen.sv
// Test pattern generator: timing from vtg_timing, pattern colour and the aligned
// one-cycle output register stage.
module video_pattern_gen
  import video_pattern_gen_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 12,
  parameter int FADE_FRAMES = 30
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  input  logic [CNT_W-1:0]  I_h_total,
  input  logic [CNT_W-1:0]  I_h_sync,
  input  logic [CNT_W-1:0]  I_h_bporch,
  input  logic [CNT_W-1:0]  I_h_res,
  input  logic [CNT_W-1:0]  I_v_total,
  input  logic [CNT_W-1:0]  I_v_sync,
  input  logic [CNT_W-1:0]  I_v_bporch,
  input  logic [CNT_W-1:0]  I_v_res,
  input  logic              I_hs_pol,
  input  logic              I_vs_pol,
  input  logic [2:0]        I_mode,
  input  logic [3:0]        I_chk_log2,
  output logic              O_de,
  output logic              O_hs,
  output logic              O_vs,
  output logic [DATA_W-1:0] O_data_r,
  output logic [DATA_W-1:0] O_data_g,
  output logic [DATA_W-1:0] O_data_b,
  output logic              O_frame_tgl,
  output logic              O_cfg_err
);

  localparam logic [DATA_W-1:0] MAX  = {DATA_W{1'b1}};
  localparam int                STEP = ((2**DATA_W) - 1) / (FADE_FRAMES - 1);

  logic             frame_start, frame_end, line_end, active, hs_lvl, vs_lvl, cfg_err;
  logic [CNT_W-1:0] x, y, h_res;
  logic [2:0]       mode;
  logic [3:0]       chk_log2;

  vtg_timing #(.CNT_W(CNT_W)) u_timing (
    .I_pxl_clk   (I_pxl_clk),
    .I_rst_n     (I_rst_n),
    .I_h_total   (I_h_total),
    .I_h_sync    (I_h_sync),
    .I_h_bporch  (I_h_bporch),
    .I_h_res     (I_h_res),
    .I_v_total   (I_v_total),
    .I_v_sync    (I_v_sync),
    .I_v_bporch  (I_v_bporch),
    .I_v_res     (I_v_res),
    .I_hs_pol    (I_hs_pol),
    .I_vs_pol    (I_vs_pol),
    .I_mode      (I_mode),
    .I_chk_log2  (I_chk_log2),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_end    (line_end),
    .active      (active),
    .hs_lvl      (hs_lvl),
    .vs_lvl      (vs_lvl),
    .cfg_err     (cfg_err),
    .x           (x),
    .y           (y),
    .h_res       (h_res),
    .mode        (mode),
    .chk_log2    (chk_log2)
  );

  function automatic logic [DATA_W-1:0] fade_level(input logic [7:0] cnt, input logic mirror);
    logic [DATA_W-1:0] c;
    c = DATA_W'(32'(cnt) * STEP);
    fade_level = mirror ? (MAX - c) : c;
  endfunction

  logic [7:0]       frame_cnt;
  logic             dir;
  logic [CNT_W-1:0] pos;
  logic [CNT_W:0]   pos_nxt;

  assign pos_nxt = {1'b0, pos} + (CNT_W+1)'(1);

  // Animation state advances on the last pixel, so the first frame after reset shows step 0.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      frame_cnt <= '0;
      dir       <= 1'b0;
      pos       <= '0;
    end else if (frame_end) begin
      if (frame_cnt == 8'(FADE_FRAMES - 1)) begin
        frame_cnt <= '0;
        dir       <= ~dir;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      pos <= (pos_nxt >= {1'b0, h_res}) ? '0 : pos_nxt[CNT_W-1:0];
    end
  end

  // Bar index tracked incrementally along the line instead of dividing x by the bar width.
  logic [CNT_W-1:0] bar_w, bar_pos;
  logic [3:0]       bar_idx;

  assign bar_w = h_res >> 3;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (!active || line_end) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (({1'b0, bar_pos} + (CNT_W+1)'(1)) >= {1'b0, bar_w}) begin
      bar_pos <= '0;
      if (bar_idx != 4'(NUM_BARS)) bar_idx <= bar_idx + 4'd1;
    end else begin
      bar_pos <= bar_pos + CNT_W'(1);
    end
  end

  mode_e             mode_sel;
  logic [2:0]        bar_rgb;
  logic [CNT_W-1:0]  xs, ys;
  logic [DATA_W-1:0] fade_c, pix_r, pix_g, pix_b;
  logic              in_movbar;

  assign mode_sel  = mode_e'(mode);
  assign bar_rgb   = bar_colour(bar_idx);
  assign xs        = x >> chk_log2;
  assign ys        = y >> chk_log2;
  assign fade_c    = fade_level(frame_cnt, dir);
  assign in_movbar = ({1'b0, x} >= {1'b0, pos}) &&
                     ({1'b0, x} <= ({1'b0, pos} + (CNT_W+1)'(MOVBAR_W - 1)));

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (mode_sel)
      MODE_FADE: begin
        pix_r = fade_c;
        pix_g = MAX - fade_c;
      end
      MODE_BARS: begin
        pix_r = {DATA_W{bar_rgb[2]}};
        pix_g = {DATA_W{bar_rgb[1]}};
        pix_b = {DATA_W{bar_rgb[0]}};
      end
      MODE_CHECKER: begin
        pix_r = {DATA_W{xs[0] ^ ys[0]}};
        pix_g = {DATA_W{xs[0] ^ ys[0]}};
        pix_b = {DATA_W{xs[0] ^ ys[0]}};
      end
      MODE_RAMP: begin
        pix_r = x[DATA_W-1:0];
        pix_g = x[DATA_W-1:0];
        pix_b = x[DATA_W-1:0];
      end
      MODE_MOVBAR: begin
        pix_r = {DATA_W{in_movbar}};
        pix_g = {DATA_W{in_movbar}};
        pix_b = {DATA_W{in_movbar}};
      end
      default: ;
    endcase
  end

  // Stage p1: every output registered once from the same counter state.
  logic              vld_p0;
  logic              vld_p1, hs_p1, vs_p1, err_p1, tgl_p1;
  logic [DATA_W-1:0] r_p1, g_p1, b_p1;

  assign vld_p0 = active && !cfg_err;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      err_p1 <= 1'b0;
      tgl_p1 <= 1'b0;
      r_p1   <= '0;
      g_p1   <= '0;
      b_p1   <= '0;
    end else begin
      vld_p1 <= vld_p0;
      hs_p1  <= hs_lvl;
      vs_p1  <= vs_lvl;
      err_p1 <= cfg_err;
      if (frame_start) tgl_p1 <= ~tgl_p1;
      r_p1   <= vld_p0 ? pix_r : '0;
      g_p1   <= vld_p0 ? pix_g : '0;
      b_p1   <= vld_p0 ? pix_b : '0;
    end
  end

  assign O_de        = vld_p1;
  assign O_hs        = hs_p1;
  assign O_vs        = vs_p1;
  assign O_cfg_err   = err_p1;
  assign O_frame_tgl = tgl_p1;
  assign O_data_r    = r_p1;
  assign O_data_g    = g_p1;
  assign O_data_b    = b_p1;

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 8, bits per colour channel; CNT_W, 12, timing counter/config width; FADE_FRAMES, 30, frames per fade half-cycle (2..255).
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
- I_pxl_clk  in  1  pixel clock
- I_rst_n  in  1  reset, asynchronous, active-low
- I_h_total, I_h_sync, I_h_bporch, I_h_res  in  CNT_W  horizontal timing, in pixels
- I_v_total, I_v_sync, I_v_bporch, I_v_res  in  CNT_W  vertical timing, in lines
- I_hs_pol, I_vs_pol  in  1  sync polarity; 1 = active-high
- I_mode  in  3  pattern select
- I_chk_log2  in  4  checker square size = 2^I_chk_log2 pixels
- O_de  out  1  active video
- O_hs, O_vs  out  1  syncs
- O_data_r, O_data_g, O_data_b  out  DATA_W  pixel colour
- O_frame_tgl  out  1  toggles once per frame
- O_cfg_err  out  1  latched configuration is illegal

Function
REQ-003 SHALL run H counter 0..h_total-1; V SHALL advance when H wraps and wrap at v_total-1.
REQ-004 SHALL latch all I_* configuration and mode inputs into shadow registers only on the cycle H=0,V=0; mid-frame input changes SHALL have no effect until the next frame.
REQ-005 Active region: H in [h_sync+h_bporch, h_sync+h_bporch+h_res-1] and V likewise; sync active for H<h_sync (V<v_sync).
REQ-006 O_de, O_hs, O_vs and O_data_* SHALL all be registered with identical 1-cycle latency from the counters, so that they are mutually aligned.
REQ-007 Sync outputs SHALL equal the active level when I_hs_pol/I_vs_pol=1, otherwise the inverted active level.
REQ-008 Outside the active region, O_data_* SHALL be 0.
REQ-009 Active-pixel coordinates x,y SHALL be zero-based from the first active pixel and line.
REQ-010 Modes: the following SHALL apply.
- 0: fade, r=c, g=MAX-c, b=0.
- 1: 8 colour bars, width = h_res>>3; order white, yellow, cyan, green, magenta, red, blue, black; pixels beyond 8 bars SHALL be black.
- 2: checkerboard, white when x[k]^y[k]=1 with k=I_chk_log2, else black.
- 3: grey ramp, all channels = x[DATA_W-1:0] (wraps).
- 4: moving bar, white where x in [pos, pos+15], else black.
- 5-7: black.
REQ-011 The fade value SHALL be c = frame_cnt*STEP, where STEP = MAX/(FADE_FRAMES-1) (integer) and MAX = 2^DATA_W-1; it SHALL be mirrored (MAX-c) when dir=1.
REQ-012 Fade update SHALL occur at frame start: frame_cnt counts 0..FADE_FRAMES-1; on wrap, frame_cnt SHALL clear and dir SHALL toggle.
REQ-013 pos SHALL increment by 1 per frame and wrap to 0 when pos+1 >= h_res.
REQ-014 O_frame_tgl SHALL toggle on the same cycle as the frame-start latch.
REQ-015 Config SHALL be illegal if h_sync+h_bporch+h_res > h_total, v_sync+v_bporch+v_res > v_total, h_total<2, or v_total<2.
REQ-016 While the latched config is illegal: O_cfg_err=1, O_de=0, data=0; syncs SHALL keep running.
REQ-017 A legal config SHALL clear O_cfg_err at the next frame-start latch.
REQ-018 All arithmetic SHALL be unsigned, computed in CNT_W+1 bits, with no truncation in the comparisons.

Reset
REQ-019 Asynchronous reset SHALL clear H, V, frame_cnt, dir and pos to 0.
REQ-020 During reset: O_de=0, O_hs=1, O_vs=1, data=0, O_frame_tgl=0, O_cfg_err=0.
REQ-021 Shadow registers SHALL load on the first clock after reset release.
REQ-022 Reset asserted mid-frame SHALL abort the frame; the first frame after release SHALL start at H=0,V=0 with full timing.

Structure
REQ-023 A shared package SHALL hold the mode encodings (MODE_FADE..MODE_MOVBAR), the colour-bar RGB table, and the bar width (16).
REQ-024 Timing counters, shadow latch, legality check and sync/de generation SHALL be one sub-module, vtg_timing; pattern logic SHALL remain in the top level.

Verification
REQ-025 Timing 1650/40/220/1280, 750/5/20/720: O_de high exactly 921600 cycles per frame; first de at H=260,V=25 (+1 cycle); hs low 40 cycles when pol=0.
REQ-026 Mode 1, h_res=1280: bars are 160 px each; pixel x=0 gives MAX,MAX,MAX; x=160 gives MAX,MAX,0; x=1279 gives 0,0,0.
REQ-027 Mode 0, DATA_W=8, FADE_FRAMES=30: STEP=8; r follows 0, 8, ..., 232 over frames 1-30, then mirrored (255-c) after the wrap; g=255-r throughout.
REQ-028 Change I_mode from 1 to 2 at V=300: bars persist to the end of the frame; checker appears at the next frame's first de.
REQ-029 Set h_res=1500 with h_total=1650: O_cfg_err=1 from the next frame, O_de=0 and hs still toggling; restore 1280: error clears one frame later.
REQ-030 Assert reset at V=400: outputs reach reset values immediately; after release, the first de occurs 260+25*1650+1 cycles later.
